mission_phase_sequencer: RTL and testbench

//  Clocked flight-phase controller around the destination check: sequences IDLE->ASCENT->DEST->DESCENT->LANDED.
//  Per accepted sensor sample it compares altitude to MAX_ALT and evaluates health = temp & ~rad & oxygen & life.

---
 rtl/mission_phase_sequencer.sv | 146 ++++++++++++++
 tb/tb_mission_phase_sequencer.sv | 232 +++++++++++++++++++++++
 2 files changed

// File: rtl/mission_phase_sequencer.sv
// mission_phase_sequencer
//   Flight-phase controller: IDLE -> ASCENT -> DEST -> DESCENT -> LANDED,
//   with a debounced health fault forcing ABORT. Each accepted sensor sample
//   compares altitude against MAX_ALT and evaluates
//   health = temp & ~rad & oxygen & life.
//
//   Handshake: a sample is consumed on a cycle where sample_valid and
//   sample_ready are both high. sample_ready depends only on the registered
//   phase, so it never depends on sample_valid. Nothing advances without a
//   consumed sample, except a start request in IDLE/LANDED.
//
// Ports
//   clk           rising-edge clock
//   rst_n         synchronous active-low reset
//   start         launch request, level, looked at only in IDLE/LANDED
//   sample_valid  sensor sample present
//   sample_ready  sample accepted this cycle (ASCENT/DEST/DESCENT/ABORT)
//   altitude      unsigned altitude, ALT_W bits
//   temp/rad/oxygen/life  health inputs
//   phase         IDLE=0 ASCENT=1 DEST=2 DESCENT=3 LANDED=4 ABORT=7 (FSM state)
//   aborted       sticky, the mission passed through ABORT
//   overshoot     sticky, altitude above MAX_ALT accepted while in DEST
//   done          high while phase is LANDED
module mission_phase_sequencer #(
  parameter int              ALT_W      = 10,
  parameter logic [ALT_W-1:0] MAX_ALT   = ALT_W'(768),
  parameter int              FAULT_HOLD = 4,
  parameter int              DWELL      = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             sample_valid,
  output logic             sample_ready,
  input  logic [ALT_W-1:0] altitude,
  input  logic             temp,
  input  logic             rad,
  input  logic             oxygen,
  input  logic             life,
  output logic [2:0]       phase,
  output logic             aborted,
  output logic             overshoot,
  output logic             done
);

  localparam logic [2:0] PH_IDLE    = 3'd0;
  localparam logic [2:0] PH_ASCENT  = 3'd1;
  localparam logic [2:0] PH_DEST    = 3'd2;
  localparam logic [2:0] PH_DESCENT = 3'd3;
  localparam logic [2:0] PH_LANDED  = 3'd4;
  localparam logic [2:0] PH_ABORT   = 3'd7;

  logic [3:0] fault_cnt, fault_nxt;
  logic [7:0] dwell_cnt, dwell_nxt;
  logic [2:0] phase_nxt;
  logic       aborted_nxt, overshoot_nxt;
  logic       acc, healthy, fault_trip;

  assign acc     = sample_valid & sample_ready;
  assign healthy = temp & ~rad & oxygen & life;
  // The current faulty sample counts toward the hold, hence the +1.
  assign fault_trip = acc & ~healthy &
                      (({1'b0, fault_cnt} + 5'd1) >= 5'(FAULT_HOLD));

  // State register
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      phase     <= PH_IDLE;
      fault_cnt <= '0;
      dwell_cnt <= '0;
      aborted   <= 1'b0;
      overshoot <= 1'b0;
      done      <= 1'b0;
    end else begin
      phase     <= phase_nxt;
      fault_cnt <= fault_nxt;
      dwell_cnt <= dwell_nxt;
      aborted   <= aborted_nxt;
      overshoot <= overshoot_nxt;
      done      <= (phase_nxt == PH_LANDED);
    end
  end

  // Next-state logic
  always_comb begin
    phase_nxt     = phase;
    fault_nxt     = fault_cnt;
    dwell_nxt     = dwell_cnt;
    aborted_nxt   = aborted;
    overshoot_nxt = overshoot;

    if (acc) begin
      if (healthy)                fault_nxt = '0;
      else if (fault_cnt != 4'hF) fault_nxt = fault_cnt + 4'd1;
    end

    case (phase)
      PH_IDLE, PH_LANDED: begin
        if (start) begin
          phase_nxt     = PH_ASCENT;
          fault_nxt     = '0;
          dwell_nxt     = '0;
          aborted_nxt   = 1'b0;
          overshoot_nxt = 1'b0;
        end
      end
      PH_ASCENT: begin
        if (fault_trip) phase_nxt = PH_ABORT;
        else if (acc && altitude >= MAX_ALT) begin
          phase_nxt = PH_DEST;
          dwell_nxt = '0;
        end
      end
      PH_DEST: begin
        if (acc && altitude > MAX_ALT) overshoot_nxt = 1'b1;
        if (fault_trip) phase_nxt = PH_ABORT;
        else if (acc && healthy) begin
          // A faulty but non-tripping sample leaves dwell_cnt where it was.
          dwell_nxt = dwell_cnt + 8'd1;
          if (({1'b0, dwell_cnt} + 9'd1) >= 9'(DWELL)) phase_nxt = PH_DESCENT;
        end
      end
      PH_DESCENT: begin
        if (fault_trip) phase_nxt = PH_ABORT;
        else if (acc && altitude == '0) phase_nxt = PH_LANDED;
      end
      PH_ABORT: begin
        // Faults no longer matter; only touchdown ends the abort.
        if (acc && altitude == '0) phase_nxt = PH_LANDED;
      end
      default: phase_nxt = PH_ABORT;   // encodings 5 and 6
    endcase

    if (phase_nxt == PH_ABORT) aborted_nxt = 1'b1;
  end

  // Output logic
  always_comb begin
    sample_ready = 1'b0;
    case (phase)
      PH_ASCENT, PH_DEST, PH_DESCENT, PH_ABORT: sample_ready = 1'b1;
      default:                                  sample_ready = 1'b0;
    endcase
  end

endmodule

// File: tb/tb_mission_phase_sequencer.sv
module tb_mission_phase_sequencer;

  localparam int MAX_A = 768;
  localparam int HOLD  = 4;
  localparam int DW    = 8;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       start = 1'b0;
  logic       sample_valid = 1'b0;
  logic       sample_ready;
  logic [9:0] altitude = '0;
  logic       temp = 1'b1, rad = 1'b0, oxygen = 1'b1, life = 1'b1;
  logic [2:0] phase;
  logic       aborted, overshoot, done;

  int total = 0;
  int bad   = 0;

  mission_phase_sequencer #(
    .ALT_W(10), .MAX_ALT(10'd768), .FAULT_HOLD(HOLD), .DWELL(DW)
  ) dut (
    .clk(clk), .rst_n(rst_n), .start(start),
    .sample_valid(sample_valid), .sample_ready(sample_ready),
    .altitude(altitude), .temp(temp), .rad(rad), .oxygen(oxygen), .life(life),
    .phase(phase), .aborted(aborted), .overshoot(overshoot), .done(done)
  );

  // Clock / reset
  always #5 clk = ~clk;

  // Reference model: tracks mission phase from the rules directly, counting
  // consecutive bad samples and healthy dwell samples as plain integers.
  int m_phase = 0;
  int m_faults = 0;
  int m_dwell = 0;
  bit m_abort = 0;
  bit m_over = 0;
  bit take, ok, trip;
  int alt_i;

  always @(posedge clk) begin
    take  = sample_valid && (m_phase == 1 || m_phase == 2 || m_phase == 3 || m_phase == 7);
    ok    = temp && !rad && oxygen && life;
    alt_i = int'(altitude);
    trip  = take && !ok && (m_faults + 1 >= HOLD) && (m_phase != 7);
    if (!rst_n) begin
      m_phase <= 0; m_faults <= 0; m_dwell <= 0; m_abort <= 0; m_over <= 0;
    end else if ((m_phase == 0 || m_phase == 4) && start) begin
      m_phase <= 1; m_faults <= 0; m_dwell <= 0; m_abort <= 0; m_over <= 0;
    end else if (take) begin
      m_faults <= ok ? 0 : ((m_faults + 1 > 15) ? 15 : m_faults + 1);
      if (trip) begin
        m_phase <= 7;
        m_abort <= 1;
      end
      if (m_phase == 2 && alt_i > MAX_A) m_over <= 1;
      if (!trip) begin
        if (m_phase == 1 && alt_i >= MAX_A) begin
          m_phase <= 2; m_dwell <= 0;
        end else if (m_phase == 2 && ok) begin
          m_dwell <= m_dwell + 1;
          if (m_dwell + 1 >= DW) m_phase <= 3;
        end else if ((m_phase == 3 || m_phase == 7) && alt_i == 0) begin
          m_phase <= 4;
        end
      end
    end
  end

  // Driver tasks
  task automatic send(input int alt, input bit faulty);
    sample_valid = 1'b1;
    altitude = 10'(alt);
    temp = 1'b1; oxygen = 1'b1; life = 1'b1; rad = faulty;
    @(posedge clk); #1;
    sample_valid = 1'b0;
    rad = 1'b0;
  endtask

  task automatic pulse_start();
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
  endtask

  task automatic do_reset();
    rst_n = 1'b0; start = 1'b0; sample_valid = 1'b0;
    @(posedge clk); @(posedge clk); #1;
    rst_n = 1'b1;
  endtask

  // Scenarios
  task automatic test_reset();
    do_reset();
    total++; if (phase !== 3'd0) begin bad++; $display("FAIL reset_phase got=%0d exp=0", phase); end
    total++; if ({aborted, overshoot, done, sample_ready} !== 4'b0000) begin bad++;
      $display("FAIL reset_flags got=%b exp=0000", {aborted, overshoot, done, sample_ready}); end
  endtask

  task automatic test_nominal();
    pulse_start();
    total++; if (phase !== 3'd1 || sample_ready !== 1'b1) begin bad++;
      $display("FAIL nom_launch phase=%0d ready=%b exp 1/1", phase, sample_ready); end
    send(100, 0); send(500, 0);
    total++; if (phase !== 3'd1) begin bad++; $display("FAIL nom_climb got=%0d exp=1", phase); end
    send(768, 0);
    total++; if (phase !== 3'd2) begin bad++; $display("FAIL nom_arrive got=%0d exp=2", phase); end
    for (int i = 0; i < DW - 1; i++) send(768, 0);
    total++; if (phase !== 3'd2) begin bad++; $display("FAIL nom_dwell7 got=%0d exp=2", phase); end
    send(768, 0);
    total++; if (phase !== 3'd3 || overshoot !== 1'b0) begin bad++;
      $display("FAIL nom_descent phase=%0d ovs=%b exp 3/0", phase, overshoot); end
    send(0, 0);
    total++; if (phase !== 3'd4 || done !== 1'b1 || aborted !== 1'b0 || sample_ready !== 1'b0) begin bad++;
      $display("FAIL nom_landed phase=%0d done=%b abt=%b rdy=%b exp 4/1/0/0", phase, done, aborted, sample_ready); end
  endtask

  task automatic test_debounce();
    pulse_start();
    for (int i = 0; i < HOLD - 1; i++) send(100, 1);
    total++; if (phase !== 3'd1) begin bad++; $display("FAIL deb_three got=%0d exp=1", phase); end
    send(100, 0);
    for (int i = 0; i < HOLD - 1; i++) send(100, 1);
    total++; if (phase !== 3'd1) begin bad++; $display("FAIL deb_rearm got=%0d exp=1", phase); end
    send(100, 1);
    total++; if (phase !== 3'd7 || aborted !== 1'b1) begin bad++;
      $display("FAIL deb_abort phase=%0d abt=%b exp 7/1", phase, aborted); end
  endtask

  task automatic test_abort_landing();
    send(5, 1);
    total++; if (phase !== 3'd7) begin bad++; $display("FAIL abl_hold got=%0d exp=7", phase); end
    send(0, 0);
    total++; if (phase !== 3'd4 || aborted !== 1'b1 || done !== 1'b1) begin bad++;
      $display("FAIL abl_landed phase=%0d abt=%b done=%b exp 4/1/1", phase, aborted, done); end
    pulse_start();
    total++; if (phase !== 3'd1 || aborted !== 1'b0 || done !== 1'b0) begin bad++;
      $display("FAIL abl_relaunch phase=%0d abt=%b done=%b exp 1/0/0", phase, aborted, done); end
  endtask

  task automatic test_tie();
    for (int i = 0; i < HOLD - 1; i++) send(100, 1);
    send(800, 1);
    total++; if (phase !== 3'd7 || overshoot !== 1'b0) begin bad++;
      $display("FAIL tie phase=%0d ovs=%b exp 7/0", phase, overshoot); end
    send(0, 0);
  endtask

  task automatic test_overshoot_dwell();
    pulse_start();
    send(768, 0);
    send(865, 0);
    total++; if (phase !== 3'd2 || overshoot !== 1'b1) begin bad++;
      $display("FAIL ovs_set phase=%0d ovs=%b exp 2/1", phase, overshoot); end
    send(865, 1); send(865, 1);
    for (int i = 0; i < DW - 2; i++) send(768, 0);
    total++; if (phase !== 3'd2) begin bad++; $display("FAIL dwell_hold got=%0d exp=2", phase); end
    send(768, 0);
    total++; if (phase !== 3'd3 || overshoot !== 1'b1) begin bad++;
      $display("FAIL dwell_done phase=%0d ovs=%b exp 3/1", phase, overshoot); end
  endtask

  task automatic test_no_valid_hold();
    start = 1'b1;
    for (int i = 0; i < 3; i++) begin @(posedge clk); #1; end
    start = 1'b0;
    total++; if (phase !== 3'd3) begin bad++; $display("FAIL hold_idle got=%0d exp=3", phase); end
    send(0, 0);
  endtask

  task automatic test_mid_reset();
    pulse_start();
    send(768, 0);
    for (int i = 0; i < 5; i++) send(768, 0);
    rst_n = 1'b0;
    @(posedge clk); #1;
    total++; if (phase !== 3'd0 || {aborted, overshoot, done, sample_ready} !== 4'b0000) begin bad++;
      $display("FAIL mid_reset phase=%0d flags=%b exp 0/0000", phase, {aborted, overshoot, done, sample_ready}); end
    rst_n = 1'b1;
    pulse_start();
    send(768, 0);
    for (int i = 0; i < DW - 1; i++) send(768, 0);
    total++; if (phase !== 3'd2) begin bad++; $display("FAIL mid_reset_dwell got=%0d exp=2", phase); end
  endtask

  task automatic test_random();
    int sel;
    do_reset();
    for (int c = 0; c < 4000; c++) begin
      rst_n = ($urandom_range(0, 399) != 0);
      start = ($urandom_range(0, 7) == 0);
      sample_valid = ($urandom_range(0, 3) != 0);
      sel = $urandom_range(0, 3);
      case (sel)
        0: altitude = 10'd0;
        1: altitude = 10'd768;
        2: altitude = 10'($urandom_range(769, 1023));
        default: altitude = 10'($urandom_range(0, 1023));
      endcase
      temp   = ($urandom_range(0, 15) != 0);
      rad    = ($urandom_range(0, 5) == 0);
      oxygen = ($urandom_range(0, 15) != 0);
      life   = ($urandom_range(0, 15) != 0);
      @(posedge clk); #1;
      total++; if (phase !== 3'(m_phase)) begin bad++; $display("FAIL rnd_phase cyc=%0d got=%0d exp=%0d", c, phase, m_phase); end
      total++; if (aborted !== m_abort) begin bad++; $display("FAIL rnd_aborted cyc=%0d got=%b exp=%b", c, aborted, m_abort); end
      total++; if (overshoot !== m_over) begin bad++; $display("FAIL rnd_overshoot cyc=%0d got=%b exp=%b", c, overshoot, m_over); end
      total++; if (done !== (m_phase == 4)) begin bad++; $display("FAIL rnd_done cyc=%0d got=%b exp=%b", c, done, m_phase == 4); end
      total++; if (sample_ready !== (m_phase == 1 || m_phase == 2 || m_phase == 3 || m_phase == 7)) begin bad++;
        $display("FAIL rnd_ready cyc=%0d got=%b phase_exp=%0d", c, sample_ready, m_phase); end
    end
    rst_n = 1'b1; start = 1'b0; sample_valid = 1'b0;
    rad = 1'b0; temp = 1'b1; oxygen = 1'b1; life = 1'b1;
  endtask

  // Sequence and report
  initial begin
    test_reset();
    test_nominal();
    test_debounce();
    test_abort_landing();
    test_tie();
    test_overshoot_dwell();
    test_no_valid_hold();
    test_mid_reset();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
